// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - BorrowIn, LSB first, over WIDTH clocks.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
//
//   state | meaning
//   IDLE  | waiting for Start; Diff/BorrowOut hold the last result
//   BUSY  | one full-subtractor step per clock, cnt counts processed bits
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic             accept;
  logic             last;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             sign_a;
  logic             sign_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    a_bit      = sh_a[0];
    b_bit      = sh_b[0];
    d_bit      = a_bit ^ b_bit ^ br;
    br_next    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state == BUSY);

  // Shift datapath: operands move right, difference bits enter at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      sh_d <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      sh_a <= A;
      sh_b <= B;
      br   <= BorrowIn;
      cnt  <= '0;
    end else if (state == BUSY) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      sh_d <= {d_bit, sh_d[WIDTH-1:1]};
      br   <= br_next;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result registers only move on the completion edge, so no partial result is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Done      <= 1'b0;
      Diff      <= '0;
      BorrowOut <= 1'b0;
    end else begin
      Done <= last;
      if (last) begin
        Diff      <= {d_bit, sh_d[WIDTH-1:1]};
        BorrowOut <= br_next;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  // Operand signs are kept aside because sh_a/sh_b are consumed by the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (accept) begin
        sign_a <= A[WIDTH-1];
        sign_b <= B[WIDTH-1];
      end
      if (last) Overflow <= (sign_a != sign_b) && (d_bit != sign_a);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       Start;
  logic [7:0] A;
  logic [7:0] B;
  logic       BorrowIn;
  logic       Busy;
  logic       Done;
  logic [7:0] Diff;
  logic       BorrowOut;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic       Overflow;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] prev_diff;
  logic       prev_bo;
  logic       prev_ovf;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .BorrowIn  (BorrowIn),
    .Busy      (Busy),
    .Done      (Done),
    .Diff      (Diff),
    .BorrowOut (BorrowOut)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .Overflow  (Overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after Done has dropped.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo);
    Start = 1'b1; A = a; B = b; BorrowIn = bin;
    @(negedge clk);
    Start = 1'b0; A = 8'($urandom); B = 8'($urandom); BorrowIn = 1'($urandom);
    chk("busy_after_accept", 32'(Busy), 32'd1);
    chk("done_after_accept", 32'(Done), 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("busy_mid", 32'(Busy), 32'd1);
      chk("done_mid", 32'(Done), 32'd0);
      chk("diff_held", 32'(Diff), 32'(prev_diff));
      chk("bout_held", 32'(BorrowOut), 32'(prev_bo));
    end
    @(negedge clk);
    chk("done_pulse", 32'(Done), 32'd1);
    chk("busy_cleared", 32'(Busy), 32'd0);
    chk("diff", 32'(Diff), 32'(ed));
    chk("borrow_out", 32'(BorrowOut), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk("overflow", 32'(Overflow), 32'(eo));
    prev_ovf = eo;
`endif
    prev_diff = ed;
    prev_bo   = eb;
    @(negedge clk);
    chk("done_drop", 32'(Done), 32'd0);
    chk("diff_after", 32'(Diff), 32'(ed));
  endtask

  initial begin
    int seen_done;
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
    vecs[9] = '{8'h12, 8'h34, 1'b1, 8'hDD, 1'b1, 1'b0};

    rst_n = 1'b0; Start = 1'b0; A = 8'h00; B = 8'h00; BorrowIn = 1'b0;
    prev_diff = 8'h00; prev_bo = 1'b0; prev_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_bout", 32'(BorrowOut), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    chk("rst_ovf", 32'(Overflow), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", 32'(Busy), 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf);

    // Start held high; operands change mid-operation and the second op starts in the Done cycle.
    Start = 1'b1; A = 8'h10; B = 8'h01; BorrowIn = 1'b0;
    repeat (3) @(negedge clk);
    A = 8'h20; B = 8'h02;
    repeat (5) @(negedge clk);
    chk("b2b_hold_first", 32'(Diff), 32'(prev_diff));
    @(negedge clk);
    chk("b2b_done1", 32'(Done), 32'd1);
    chk("b2b_diff1", 32'(Diff), 32'h0F);
    chk("b2b_busy_gap", 32'(Busy), 32'd0);
    @(negedge clk);
    Start = 1'b0;
    chk("b2b_reaccept", 32'(Busy), 32'd1);
    chk("b2b_done_drop", 32'(Done), 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("b2b_diff_held", 32'(Diff), 32'h0F);
      chk("b2b_no_done", 32'(Done), 32'd0);
    end
    @(negedge clk);
    chk("b2b_done2", 32'(Done), 32'd1);
    chk("b2b_diff2", 32'(Diff), 32'h1E);
    chk("b2b_bout2", 32'(BorrowOut), 32'd0);
    prev_diff = 8'h1E; prev_bo = 1'b0;
    @(negedge clk);

    // Asynchronous reset part-way through an operation.
    Start = 1'b1; A = 8'h03; B = 8'h05; BorrowIn = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_diff", 32'(Diff), 32'd0);
    chk("mid_rst_bout", 32'(BorrowOut), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Done === 1'b1 || Busy === 1'b1) seen_done = 1;
    end
    chk("no_done_after_rst", 32'(seen_done), 32'd0);
    prev_diff = 8'h00; prev_bo = 1'b0;
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
